// File: rtl/parallel_port_pkg.sv
// Shared constants for the debounced Avalon-MM input port: register map,
// edge-mode encodings and the post-reset priming length.
package parallel_port_pkg;

  localparam logic [1:0] REG_DATA         = 2'd0;
  localparam logic [1:0] REG_DEBOUNCE     = 2'd1;
  localparam logic [1:0] REG_IRQ_MASK     = 2'd2;
  localparam logic [1:0] REG_EDGE_CAPTURE = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned PRIME_CYCLES = 3;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, saturating debounce counter,
// committed stable level and single-cycle rise/fall pulses on commit.
module debounce_bit #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             prime,
  input  logic [CNT_W-1:0] threshold,
  input  logic             din,
  output logic             dout,
  output logic             rise,
  output logic             fall
);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mismatch;
  logic             commit;

  always_comb begin
    mismatch = sync2_q ^ stable_q;
    commit   = ~prime & mismatch & (cnt_q >= threshold);
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (prime) begin
      // Adopt the synchronised level without reporting an edge.
      stable_d = sync2_q;
      cnt_d    = '0;
    end else if (!mismatch) begin
      cnt_d = '0;
    end else if (commit) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign dout = stable_q;
  assign rise = commit & sync2_q;
  assign fall = commit & ~sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/parallel_port_irq.sv
// Debounced parallel input port: per-bit filters, register file with
// edge capture / interrupt mask, and a level-sensitive IRQ.
module parallel_port_irq
  import parallel_port_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned DEBOUNCE_RESET = 1000000,
  parameter int unsigned EDGE_MODE      = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  localparam logic [63:0] DEB_MASK64 = (64'd1 << CNT_W) - 64'd1;
  localparam logic [63:0] IN_MASK64  = (64'd1 << WIDTH) - 64'd1;
  localparam logic [31:0] DEB_MASK   = DEB_MASK64[31:0];
  localparam logic [31:0] IN_MASK    = IN_MASK64[31:0];
  localparam logic        MODE_RISE  = (EDGE_MODE != EDGE_FALLING);
  localparam logic        MODE_FALL  = (EDGE_MODE != EDGE_RISING);

  // Register words keep their unused upper bits at zero so reads need no masking.
  logic [31:0]      debounce_q;
  logic [31:0]      debounce_d;
  logic [31:0]      irq_mask_q;
  logic [31:0]      irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q;
  logic [WIDTH-1:0] edge_cap_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;
  logic             irq_d;
  logic [1:0]       prime_cnt_q;
  logic [1:0]       prime_cnt_d;

  logic             prime;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_word;
  logic             wr_en;
  logic             rd_en;

  assign prime       = (prime_cnt_q != 2'(PRIME_CYCLES));
  assign prime_cnt_d = prime ? prime_cnt_q + 2'd1 : prime_cnt_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .CNT_W(CNT_W)
    ) u_debounce_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .prime    (prime),
      .threshold(debounce_q[CNT_W-1:0]),
      .din      (in_port[gi]),
      .dout     (stable[gi]),
      .rise     (rise[gi]),
      .fall     (fall[gi])
    );
  end

  assign edge_set = (rise & {WIDTH{MODE_RISE}}) | (fall & {WIDTH{MODE_FALL}});
  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign edge_clr = (wr_en && address == REG_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    debounce_d = debounce_q;
    irq_mask_d = irq_mask_q;
    if (wr_en && address == REG_DEBOUNCE) debounce_d = writedata & DEB_MASK;
    if (wr_en && address == REG_IRQ_MASK) irq_mask_d = writedata & IN_MASK;
    // A new edge wins over a simultaneous write-1-to-clear.
    edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;
    irq_d      = |(edge_cap_d & irq_mask_d[WIDTH-1:0]);
  end

  always_comb begin
    rd_word = '0;
    case (address)
      REG_DATA:     rd_word[WIDTH-1:0] = stable;
      REG_DEBOUNCE: rd_word = debounce_q;
      REG_IRQ_MASK: rd_word = irq_mask_q;
      default:      rd_word[WIDTH-1:0] = edge_cap_q;
    endcase
    readdata_d = rd_en ? rd_word : readdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      debounce_q  <= 32'(DEBOUNCE_RESET) & DEB_MASK;
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
      prime_cnt_q <= '0;
    end else begin
      debounce_q  <= debounce_d;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_parallel_port_irq.sv
// Bench for parallel_port_irq: an any-edge and a rising-only instance share
// all inputs and are compared every cycle against a behavioural model.
module tb_parallel_port_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata_any;
  logic [31:0] readdata_rise;
  logic        irq_any;
  logic        irq_rise;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  parallel_port_irq #(.WIDTH(4), .CNT_W(20), .DEBOUNCE_RESET(4), .EDGE_MODE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata_any),
    .irq(irq_any), .in_port(in_port)
  );

  parallel_port_irq #(.WIDTH(4), .CNT_W(20), .DEBOUNCE_RESET(4), .EDGE_MODE(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata_rise),
    .irq(irq_rise), .in_port(in_port)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A bit's level is accepted once the synchronised input (input delayed two
  // samples) has disagreed with it for more than DEBOUNCE consecutive cycles.
  logic [3:0]  s1_m, s2_m, stab_m;
  int          run_m [4];
  int          prime_m;
  logic [31:0] deb_m, mask_m;
  logic [3:0]  ecap_m [2];
  logic [31:0] rd_m [2];
  logic        irq_m [2];
  bit          seen = 0;
  logic [3:0]  rise_v, fall_v, clr_v, stab_old;

  always @(posedge clk) begin
    if (!reset_n) begin
      s1_m = 0; s2_m = 0; stab_m = 0; prime_m = 3;
      for (int b = 0; b < 4; b++) run_m[b] = 0;
      deb_m = 32'd4; mask_m = 0;
      for (int k = 0; k < 2; k++) begin
        ecap_m[k] = 0; rd_m[k] = 0; irq_m[k] = 0;
      end
    end else begin
      rise_v = 0; fall_v = 0; stab_old = stab_m;
      for (int b = 0; b < 4; b++) begin
        if (prime_m > 0) begin
          stab_m[b] = s2_m[b]; run_m[b] = 0;
        end else if (s2_m[b] == stab_m[b]) begin
          run_m[b] = 0;
        end else begin
          run_m[b] = run_m[b] + 1;
          if (run_m[b] > int'(deb_m)) begin
            stab_m[b] = s2_m[b]; run_m[b] = 0;
            if (s2_m[b]) rise_v[b] = 1'b1; else fall_v[b] = 1'b1;
          end
        end
      end
      if (prime_m > 0) prime_m = prime_m - 1;
      if (chipselect && read) begin
        for (int k = 0; k < 2; k++) begin
          case (address)
            2'd0: rd_m[k] = {28'b0, stab_old};
            2'd1: rd_m[k] = deb_m;
            2'd2: rd_m[k] = mask_m;
            default: rd_m[k] = {28'b0, ecap_m[k]};
          endcase
        end
      end
      clr_v = (chipselect && write && address == 2'd3) ? writedata[3:0] : 4'b0;
      if (chipselect && write && address == 2'd1) deb_m = writedata & 32'h000F_FFFF;
      if (chipselect && write && address == 2'd2) mask_m = writedata & 32'h0000_000F;
      ecap_m[0] = (ecap_m[0] & ~clr_v) | rise_v | fall_v;
      ecap_m[1] = (ecap_m[1] & ~clr_v) | rise_v;
      for (int k = 0; k < 2; k++) irq_m[k] = |(ecap_m[k] & mask_m[3:0]);
      s2_m = s1_m; s1_m = in_port;
    end
    seen = 1;
  end

  always @(negedge clk) begin
    if (seen) begin
      check("rd_any", readdata_any, rd_m[0]);
      check("rd_rise", readdata_rise, rd_m[1]);
      check("irq_any", {31'b0, irq_any}, {31'b0, irq_m[0]});
      check("irq_rise", {31'b0, irq_rise}, {31'b0, irq_m[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0;
    $display("write addr %0d data %h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] da, output logic [31:0] db);
    address = a; chipselect = 1'b1; read = 1'b1;
    tick();
    chipselect = 1'b0; read = 1'b0;
    da = readdata_any; db = readdata_rise;
    $display("read addr %0d: any %h rise %h", a, da, db);
  endtask

  initial begin
    logic [31:0] ra, rb, tmp;
    reset_n = 1'b0; address = 0; chipselect = 0; read = 0; write = 0;
    writedata = 0; in_port = 4'hF;
    repeat (3) tick();
    check("reset_rd", readdata_any, 32'h0);
    check("reset_irq", {31'b0, irq_any}, 32'h0);
    reset_n = 1'b1;

    // Idle-high inputs are adopted during priming without edges.
    repeat (6) tick();
    check("prime_irq", {31'b0, irq_any}, 32'h0);
    bus_read(2'd0, ra, rb);
    check("prime_data", ra, 32'hF);
    bus_read(2'd3, ra, rb);
    check("prime_ecap_any", ra, 32'h0);
    check("prime_ecap_rise", rb, 32'h0);
    bus_read(2'd1, ra, rb);
    check("deb_reset", ra, 32'd4);

    // Bit 0 falls; commit after 3 + DEBOUNCE edges.
    bus_write(2'd2, 32'hFFFF_FFF1);
    in_port = 4'hE;
    repeat (6) tick();
    check("fall_irq_e6", {31'b0, irq_any}, 32'h0);
    tick();
    check("fall_irq_e7", {31'b0, irq_any}, 32'h1);
    check("fall_irq_rise_e7", {31'b0, irq_rise}, 32'h0);
    check("model_stable", {28'b0, stab_m}, 32'hE);
    bus_read(2'd0, ra, rb);
    check("fall_data", ra, 32'hE);
    bus_read(2'd2, ra, rb);
    check("mask_read", ra, 32'h1);

    // Bit 1 bounces with 3-cycle runs: never long enough to commit.
    for (int t = 0; t < 10; t++) begin
      in_port[1] = ~in_port[1];
      repeat (3) tick();
    end
    bus_read(2'd3, ra, rb);
    check("bounce_ecap_any", ra, 32'h1);
    check("bounce_ecap_rise", rb, 32'h0);
    in_port[1] = 1'b0;
    repeat (6) tick();
    bus_read(2'd3, ra, rb);
    check("settle_read_pre", ra, 32'h1);
    bus_read(2'd3, ra, rb);
    check("settle_read_post", ra, 32'h3);
    check("settle_rise", rb, 32'h0);
    bus_write(2'd3, 32'hF);

    // Bit 0 rises; W1C lands on the commit edge and loses.
    in_port[0] = 1'b1;
    repeat (6) tick();
    bus_write(2'd3, 32'h1);
    check("w1c_race_irq_any", {31'b0, irq_any}, 32'h1);
    check("w1c_race_irq_rise", {31'b0, irq_rise}, 32'h1);
    tick();
    bus_write(2'd3, 32'h1);
    check("w1c_clear_irq", {31'b0, irq_any}, 32'h0);
    check("model_irq_clr", {31'b0, irq_m[0]}, 32'h0);

    // Bit 2 falls then rises: the rising-only instance sees only the second.
    in_port[2] = 1'b0;
    repeat (8) tick();
    bus_read(2'd3, ra, rb);
    check("b2_fall_any", ra, 32'h4);
    check("b2_fall_rise", rb, 32'h0);
    in_port[2] = 1'b1;
    repeat (8) tick();
    bus_read(2'd3, ra, rb);
    check("b2_rise_any", ra, 32'h4);
    check("b2_rise_rise", rb, 32'h4);

    // Threshold lowered below a running count commits on the next edge.
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'hF);
    bus_write(2'd1, 32'd1000);
    in_port[3] = 1'b0;
    repeat (502) tick();
    bus_write(2'd1, 32'd10);
    check("lower_thr_irq_pre", {31'b0, irq_any}, 32'h0);
    tick();
    check("lower_thr_irq_post", {31'b0, irq_any}, 32'h1);
    check("lower_thr_irq_rise", {31'b0, irq_rise}, 32'h0);
    check("model_irq_thr", {31'b0, irq_m[0]}, 32'h1);

    // Reset mid-count: no edge reported once priming adopts the new level.
    in_port[3] = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    bus_read(2'd3, ra, rb);
    check("rst_mid_ecap_any", ra, 32'h0);
    check("rst_mid_ecap_rise", rb, 32'h0);
    bus_read(2'd0, ra, rb);
    check("rst_mid_data", ra, 32'hD);
    bus_read(2'd1, ra, rb);
    check("rst_mid_deb", ra, 32'd4);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 15);
      chipselect = 0; read = 0; write = 0;
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      if (r < 4) begin
        chipselect = 1; read = 1;
      end else if (r < 6) begin
        chipselect = 1; write = 1;
        if (address == 2'd1) begin
          tmp = $urandom;
          writedata = (tmp & 32'hFFF0_0000) | 32'($urandom_range(0, 6));
        end
      end else if (r == 6) begin
        read = 1; write = 1;
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) in_port[b] = ~in_port[b];
      reset_n = ($urandom_range(0, 799) != 0);
      tick();
    end
    chipselect = 0; read = 0; write = 0; reset_n = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
